hazard_forward_unit: RTL and testbench

//  Parametrised successor to the combinational forwarding unit. Tracks the destination of every
//  in-flight instruction in an internal per-stage scoreboard. For the decode-stage instruction it

---
 rtl/hazard_forward_unit_pkg.sv | 27 ++
 rtl/hazard_forward_unit_match.sv | 46 ++++
 rtl/hazard_forward_unit.sv | 98 +++++++++
 tb/tb_hazard_forward_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants and types for the hazard/forwarding unit.
// Select encoding, stage indices, scoreboard entry layout.
package hazard_forward_unit_pkg;

  // fwd_sel value meaning "read the register file"
  localparam int SEL_REGFILE = 0;

  // default stage positions of scoreboard entries
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam int ADDR_LEN_DEF = 5;

  // select width: 0 for regfile plus one code per entry
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // one in-flight producer, default address width
  typedef struct packed {
    logic                    valid;
    logic [ADDR_LEN_DEF-1:0] addr;
    logic                    is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_forward_unit_match.sv
// One source operand checked against every scoreboard entry.
// In: enable, source address, entry vectors. Out: select, unready.
module fwd_src_match #(
  parameter int ADDR_LEN         = 5,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SEL_W            = 2
) (
  input  logic                      en_i,
  input  logic [ADDR_LEN-1:0]       src_addr_i,
  input  logic [DEPTH-1:0]          ent_valid_i,
  input  logic [DEPTH*ADDR_LEN-1:0] ent_addr_i,
  input  logic [DEPTH-1:0]          ent_load_i,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      unready_o
);

  logic [DEPTH-1:0] hit;

  // $zero is hardwired, so it never matches
  always_comb begin
    hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = en_i
            && (src_addr_i != '0)
            && ent_valid_i[k]
            && (ent_addr_i[k*ADDR_LEN +: ADDR_LEN]
                == src_addr_i);
    end
  end

  // walk oldest to youngest so the youngest
  // producer overwrites and wins
  always_comb begin
    sel_o     = '0;
    unready_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_o     = SEL_W'(k + 1);
        unready_o = ent_load_i[k]
                 && (k < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Scoreboard-based forwarding select and load-use stall for decode.
// In: decode instr info, flush, freeze. Out: fwd_sel, hazard_stall, stall_count.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter  int ADDR_LEN         = 5,
  parameter  int NUM_SRC          = 2,
  parameter  int DEPTH            = 3,
  parameter  int LOAD_READY_STAGE = 1,
  parameter  int CNT_W            = 16,
  localparam int SEL_W            = sel_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic                        id_reg_write,
  input  logic                        id_is_load,
  input  logic [ADDR_LEN-1:0]         id_dst_addr,
  input  logic [NUM_SRC-1:0]          id_src_valid,
  input  logic [NUM_SRC*ADDR_LEN-1:0] id_src_addr,
  input  logic                        flush,
  input  logic                        freeze,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        hazard_stall,
  output logic [CNT_W-1:0]            stall_count
);

  // entry k lives at bit k / slice k
  logic [DEPTH-1:0]          vld_q, vld_d;
  logic [DEPTH-1:0]          ld_q, ld_d;
  logic [DEPTH*ADDR_LEN-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [NUM_SRC*SEL_W-1:0]  sel_raw;
  logic [NUM_SRC-1:0]        unready;
  logic                      bubble;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(
      .ADDR_LEN         (ADDR_LEN),
      .DEPTH            (DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SEL_W            (SEL_W)
    ) u_match (
      .en_i        (id_valid & id_src_valid[g]),
      .src_addr_i  (id_src_addr[g*ADDR_LEN +: ADDR_LEN]),
      .ent_valid_i (vld_q),
      .ent_addr_i  (addr_q),
      .ent_load_i  (ld_q),
      .sel_o       (sel_raw[g*SEL_W +: SEL_W]),
      .unready_o   (unready[g])
    );
  end

  assign hazard_stall = |unready;
  // a stalled instruction is re-decoded next cycle,
  // so its selects are meaningless now
  assign fwd_sel      = hazard_stall ? '0 : sel_raw;
  assign stall_count  = cnt_q;
  assign bubble       = hazard_stall | flush;

  always_comb begin
    vld_d  = vld_q;
    ld_d   = ld_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (!freeze) begin
      // advance every producer one stage; oldest drops
      vld_d  = vld_q << 1;
      ld_d   = ld_q << 1;
      addr_d = addr_q << ADDR_LEN;
      if (!bubble) begin
        vld_d[0] = id_valid && id_reg_write
                && (id_dst_addr != '0);
        ld_d[0]  = id_is_load;
        addr_d[ADDR_LEN-1:0] = id_dst_addr;
      end
      if (hazard_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      ld_q   <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ld_q   <= ld_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: default instance and a DEPTH=4/NUM_SRC=3/LRS=2/CNT_W=2 instance.
// Reference model tracks in-flight producers as plain arrays.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_reg_write = 1'b0;
  logic        id_is_load = 1'b0;
  logic [4:0]  dst = '0;
  logic [2:0]  sv = '0;
  logic [14:0] sa = '0;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;

  logic [3:0]  sel_a;
  logic        stall_a;
  logic [15:0] cnt_a;
  logic [8:0]  sel_b;
  logic        stall_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  hazard_forward_unit u_a (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_dst_addr(dst),
    .id_src_valid(sv[1:0]), .id_src_addr(sa[9:0]),
    .flush(flush), .freeze(freeze),
    .fwd_sel(sel_a), .hazard_stall(stall_a),
    .stall_count(cnt_a)
  );

  hazard_forward_unit #(
    .DEPTH(4), .NUM_SRC(3),
    .LOAD_READY_STAGE(2), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_dst_addr(dst),
    .id_src_valid(sv), .id_src_addr(sa),
    .flush(flush), .freeze(freeze),
    .fwd_sel(sel_b), .hazard_stall(stall_b),
    .stall_count(cnt_b)
  );

  typedef struct {
    logic [8:0] sel;
    bit         stall;
    int         cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  // per-instance configuration
  int c_depth[2] = '{3, 4};
  int c_ns[2]    = '{2, 3};
  int c_lrs[2]   = '{1, 2};
  int c_max[2]   = '{65535, 3};
  int c_sw[2]    = '{2, 3};

  // model: list of in-flight producers, index = stages past decode
  bit         m_v[2][4];
  logic [4:0] m_a[2][4];
  bit         m_l[2][4];
  int         m_cnt[2];
  bit         exp_stall[2];

  function automatic void predict(input int n,
                                  output logic [8:0] sel,
                                  output bit stall);
    logic [4:0] src;
    int win;
    sel = '0;
    stall = 1'b0;
    for (int i = 0; i < c_ns[n]; i++) begin
      src = sa[i*5 +: 5];
      win = -1;
      for (int k = 0; k < c_depth[n]; k++)
        if (win < 0 && id_valid && sv[i] && src != 0
            && m_v[n][k] && m_a[n][k] == src)
          win = k;
      if (win >= 0) begin
        sel = sel | (9'(win + 1) << (i * c_sw[n]));
        if (m_l[n][win] && win < c_lrs[n]) stall = 1'b1;
      end
    end
    if (stall) sel = '0;
  endfunction

  task automatic step(input int n);
    if (rst) begin
      for (int k = 0; k < 4; k++) m_v[n][k] = 1'b0;
      m_cnt[n] = 0;
    end else if (!freeze) begin
      for (int k = c_depth[n] - 1; k > 0; k--) begin
        m_v[n][k] = m_v[n][k-1];
        m_a[n][k] = m_a[n][k-1];
        m_l[n][k] = m_l[n][k-1];
      end
      if (exp_stall[n] || flush) begin
        m_v[n][0] = 1'b0;
      end else begin
        m_v[n][0] = id_valid && id_reg_write && dst != 0;
        m_a[n][0] = dst;
        m_l[n][0] = id_is_load;
      end
      if (exp_stall[n] && m_cnt[n] < c_max[n])
        m_cnt[n]++;
    end
  endtask

  task automatic apply(input bit r, input bit v,
                       input bit rw, input bit ld,
                       input logic [4:0] d,
                       input logic [2:0] s_v,
                       input logic [14:0] s_a,
                       input bit fl, input bit fz);
    exp_t e;
    @(posedge clk);
    step(0);
    step(1);
    #1;
    rst = r; id_valid = v; id_reg_write = rw;
    id_is_load = ld; dst = d; sv = s_v; sa = s_a;
    flush = fl; freeze = fz;
    for (int n = 0; n < 2; n++) begin
      predict(n, e.sel, e.stall);
      e.cnt = m_cnt[n];
      exp_stall[n] = e.stall;
      if (n == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("sel_a", int'(sel_a), int'(e.sel));
      chk("stall_a", int'(stall_a), int'(e.stall));
      chk("cnt_a", int'(cnt_a), e.cnt);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("sel_b", int'(sel_b), int'(e.sel));
      chk("stall_b", int'(stall_b), int'(e.stall));
      chk("cnt_b", int'(cnt_b), e.cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit r, v, rw, ld, fl, fz;
    logic [4:0] d;
    logic [2:0] s_v;
    logic [14:0] s_a;
    exp_stall[0] = 1'b0;
    exp_stall[1] = 1'b0;
    // reset, then checks of the empty scoreboard
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 1, 0, 5'd3, 3'b011, {5'd0, 5'd2, 5'd3}, 0, 0);
    // ALU chain on $3
    apply(0, 1, 1, 0, 5'd4, 3'b011, {5'd0, 5'd5, 5'd3}, 0, 0);
    apply(0, 1, 1, 0, 5'd10, 3'b001, {5'd0, 5'd0, 5'd3}, 0, 0);
    apply(0, 1, 1, 0, 5'd11, 3'b001, {5'd0, 5'd0, 5'd3}, 0, 0);
    // load-use on $8, consumer held while stalled
    apply(0, 1, 1, 1, 5'd8, 3'b000, 15'd0, 0, 0);
    apply(0, 1, 1, 0, 5'd9, 3'b011, {5'd0, 5'd8, 5'd8}, 0, 0);
    apply(0, 1, 1, 0, 5'd9, 3'b011, {5'd0, 5'd8, 5'd8}, 0, 0);
    apply(0, 1, 1, 0, 5'd9, 3'b011, {5'd0, 5'd8, 5'd8}, 0, 0);
    // $zero producer and consumer
    apply(0, 1, 1, 0, 5'd0, 3'b000, 15'd0, 0, 0);
    apply(0, 1, 1, 0, 5'd12, 3'b011, 15'd0, 0, 0);
    // load-use under freeze, then flush, then reset mid-stall
    apply(0, 1, 1, 1, 5'd7, 3'b000, 15'd0, 0, 0);
    apply(0, 1, 1, 0, 5'd13, 3'b001, {10'd0, 5'd7}, 0, 1);
    apply(0, 1, 1, 0, 5'd13, 3'b001, {10'd0, 5'd7}, 0, 1);
    apply(0, 1, 1, 0, 5'd13, 3'b001, {10'd0, 5'd7}, 0, 1);
    apply(0, 1, 1, 0, 5'd13, 3'b001, {10'd0, 5'd7}, 1, 0);
    apply(0, 1, 1, 1, 5'd6, 3'b000, 15'd0, 0, 0);
    apply(0, 1, 1, 0, 5'd14, 3'b001, {10'd0, 5'd6}, 0, 0);
    apply(1, 1, 1, 0, 5'd14, 3'b001, {10'd0, 5'd6}, 0, 0);
    apply(0, 1, 1, 0, 5'd14, 3'b001, {10'd0, 5'd6}, 0, 0);
    // randomized traffic over a small register window
    for (int it = 0; it < 3000; it++) begin
      r  = ($urandom_range(0, 99) < 2);
      fz = ($urandom_range(0, 99) < 10);
      fl = ($urandom_range(0, 99) < 8);
      v  = ($urandom_range(0, 99) < 85);
      rw = ($urandom_range(0, 99) < 80);
      ld = ($urandom_range(0, 99) < 35);
      d  = 5'($urandom_range(0, 6));
      for (int i = 0; i < 3; i++) begin
        s_v[i] = ($urandom_range(0, 99) < 85);
        s_a[i*5 +: 5] = 5'($urandom_range(0, 6));
      end
      apply(r, v, rw, ld, d, s_v, s_a, fl, fz);
    end
    repeat (3) @(negedge clk);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
